mem_port_arbiter: RTL and testbench

Shares the single 256-bit data-memory port between the instruction-side requester (port 0) and the data cache (port 1). Sits between both caches' memory interfaces and the memory model. Grants the port for a whole transaction: grant holds while the owner keeps its enable high, so a dcache write-back followed by its refill is never interleaved. Inserts a one-cycle enable-low gap between owners so the memory sees a clean new request.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_sat_counter.sv | 21 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
// Contents: arb_state_t (IDLE/OWN0/OWN1), port-id constants, default widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// rtl/mem_arb_sat_counter.sv - saturating grant counter
// Ports: clk_i clock; rst_i async active-low clear; inc_i increment request;
//        count_o current count, holds at all-ones.
module mem_arb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between ifetch (m0) and dcache (m1)
// Ports: clk_i, rst_i (async active-low); m0_*/m1_* requester side
//        (enable/write/addr/data in, ack/data out); mem_* memory side;
//        grant_o one-hot owner; m0_grants_o/m1_grants_o saturating grant counts.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of
//        fixed priority to port 1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic [CNT_W-1:0]  m0_grants_o,
  output logic [CNT_W-1:0]  m1_grants_o
);

  arb_state_t state;
  logic       pick1;
  logic       inc0;
  logic       inc1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  // On a tie the port that did not win last time takes the grant.
  assign pick1 = m1_enable_i && (!m0_enable_i || (last_grant == PORT0));
`else
  assign pick1 = m1_enable_i;
`endif

  assign inc1 = (state == IDLE) && pick1;
  assign inc0 = (state == IDLE) && m0_enable_i && !pick1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      grant_o <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= PORT0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inc1) begin
            state   <= OWN1;
            grant_o <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= PORT1;
`endif
          end else if (inc0) begin
            state   <= OWN0;
            grant_o <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= PORT0;
`endif
          end
        end
        // Dropping enable always passes through IDLE, which gives the
        // memory a one-cycle enable-low gap before any new owner.
        OWN0: begin
          if (!m0_enable_i) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        OWN1: begin
          if (!m1_enable_i) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Memory-side mux depends only on state and requester inputs, never on
  // mem_ack_i, so no ack-to-request loop exists.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    case (state)
      OWN0: begin
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
      end
      OWN1: begin
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

  mem_arb_sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (inc0),
    .count_o (m0_grants_o)
  );

  mem_arb_sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (inc1),
    .count_o (m1_grants_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int N_CYC  = 3000;

  logic              clk;
  logic              rst_n;
  logic              en [2];
  logic              wr [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              m0_ack, m1_ack;
  logic [DATA_W-1:0] m0_rd, m1_rd;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        grant;
  logic [CNT_W-1:0]  g0, g1;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .m0_enable_i  (en[0]),
    .m0_write_i   (wr[0]),
    .m0_addr_i    (addr[0]),
    .m0_data_i    (wdata[0]),
    .m0_ack_o     (m0_ack),
    .m0_data_o    (m0_rd),
    .m1_enable_i  (en[1]),
    .m1_write_i   (wr[1]),
    .m1_addr_i    (addr[1]),
    .m1_data_i    (wdata[1]),
    .m1_ack_o     (m1_ack),
    .m1_data_o    (m1_rd),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .grant_o      (grant),
    .m0_grants_o  (g0),
    .m1_grants_o  (g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              men;
    logic              mwr;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic              a0;
    logic              a1;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  c0;
    logic [CNT_W-1:0]  c1;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_enable", DATA_W'(mem_en), DATA_W'(e.men));
        chk("mem_write", DATA_W'(mem_wr), DATA_W'(e.mwr));
        chk("mem_addr", DATA_W'(mem_addr), DATA_W'(e.maddr));
        chk("mem_data", mem_wdata, e.mdata);
        chk("m0_ack", DATA_W'(m0_ack), DATA_W'(e.a0));
        chk("m1_ack", DATA_W'(m1_ack), DATA_W'(e.a1));
        chk("grant", DATA_W'(grant), DATA_W'(e.grant));
        chk("m0_grants", DATA_W'(g0), DATA_W'(e.c0));
        chk("m1_grants", DATA_W'(g1), DATA_W'(e.c1));
        chk("m0_rdata", m0_rd, e.rdata);
        chk("m1_rdata", m1_rd, e.rdata);
      end
    end
  end

  // Reference model: owner is -1 when the port is free.
  int owner;
  int cnt [2];
  int last;
  // Requester transaction state.
  bit active [2];
  int need [2];
  int done [2];
  bit ack_prev [2];

  task automatic model_reset();
    owner = -1;
    cnt[0] = 0;
    cnt[1] = 0;
    last = 0;
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      if (en[0] || en[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (en[0] && en[1]) w = (last == 1) ? 0 : 1;
        else w = en[1] ? 1 : 0;
`else
        w = en[1] ? 1 : 0;
`endif
        owner = w;
        last = w;
        if (cnt[w] < CNT_MAX) cnt[w]++;
      end
    end else if (!en[owner]) begin
      owner = -1;
    end
  endtask

  task automatic drive_and_expect();
    exp_t e;
    bit   busy;
    for (int p = 0; p < 2; p++) begin
      if (ack_prev[p] && active[p]) done[p]++;
      if (active[p]) begin
        if (done[p] >= need[p]) begin
          active[p] = 1'b0;
          en[p] = 1'b0;
        end else if (need[p] == 2 && done[p] == 1 && wr[p]) begin
          // write-back finished, switch to the refill read under the same grant
          wr[p] = 1'b0;
          addr[p] = $urandom;
        end
      end else if (!en[p] && $urandom_range(0, 3) == 0) begin
        active[p] = 1'b1;
        en[p] = 1'b1;
        need[p] = $urandom_range(1, 2);
        done[p] = 0;
        wr[p] = (need[p] == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        addr[p] = $urandom;
        wdata[p] = rand_line();
      end else if (!active[p]) begin
        en[p] = 1'b0;
      end
    end
    busy = (owner >= 0) && en[owner];
    mem_ack = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    mem_rdata = rand_line();

    e.men = busy;
    e.mwr = (owner >= 0) ? wr[owner] : 1'b0;
    e.maddr = (owner >= 0) ? addr[owner] : '0;
    e.mdata = (owner >= 0) ? wdata[owner] : '0;
    e.a0 = (owner == 0) && mem_ack;
    e.a1 = (owner == 1) && mem_ack;
    e.grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e.c0 = CNT_W'(cnt[0]);
    e.c1 = CNT_W'(cnt[1]);
    e.rdata = mem_rdata;
    ack_prev[0] = e.a0;
    ack_prev[1] = e.a1;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      en[p] = 1'b0;
      wr[p] = 1'b0;
      addr[p] = '0;
      wdata[p] = '0;
      active[p] = 1'b0;
      need[p] = 0;
      done[p] = 0;
      ack_prev[p] = 1'b0;
    end
    model_reset();

    #1;
    chk("reset_mem_enable", DATA_W'(mem_en), '0);
    chk("reset_grant", DATA_W'(grant), '0);
    chk("reset_m0_grants", DATA_W'(g0), '0);
    chk("reset_m1_grants", DATA_W'(g1), '0);
    chk("reset_acks", DATA_W'({m0_ack, m1_ack}), '0);

    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      if (!rst_n) rst_n = 1'b1;
      drive_and_expect();
      if (cyc == 700 || cyc == 1900) begin
        // asynchronous reset in the middle of the cycle
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_enable", DATA_W'(mem_en), '0);
        chk("async_rst_grant", DATA_W'(grant), '0);
        chk("async_rst_m0_grants", DATA_W'(g0), '0);
        chk("async_rst_m1_grants", DATA_W'(g1), '0);
        chk("async_rst_acks", DATA_W'({m0_ack, m1_ack}), '0);
        ack_prev[0] = 1'b0;
        ack_prev[1] = 1'b0;
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
